// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced, edge-detected, auto-repeating push buttons
//
// Ports:
//   clk           single clock, all state on the rising edge
//   reset         asynchronous active-low reset
//   raw_buttons   asynchronous physical button inputs (polarity set by ACTIVE_LOW)
//   enable        synchronous enable for pulse generation
//   level         debounced pressed state, 1 = pressed
//   press         one-cycle pulse in the first cycle level shows 1
//   release_pulse one-cycle pulse in the first cycle level shows 0
//   action        press pulses OR'd with auto-repeat pulses
//   any_action    OR reduction of action, same timing as action

module button_conditioner #(
   parameter int                     NUM_BUTTONS     = 4,
   parameter int                     DEBOUNCE_CYCLES = 250000,
   parameter int                     REPEAT_DELAY    = 25000000,
   parameter int                     REPEAT_RATE     = 6250000,
   parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = '1,
   parameter bit                     ACTIVE_LOW      = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] raw_buttons,
   input  logic                   enable,
   output logic [NUM_BUTTONS-1:0] level,
   output logic [NUM_BUTTONS-1:0] press,
   output logic [NUM_BUTTONS-1:0] release_pulse,
   output logic [NUM_BUTTONS-1:0] action,
   output logic                   any_action
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   // The toggle happens on the edge where the count would reach DEBOUNCE_CYCLES,
   // so the comparison is against the value one below it.
   localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
   localparam logic [RPT_W-1:0] DELAY_END = RPT_W'(REPEAT_DELAY);
   localparam logic [RPT_W-1:0] RATE_END  = RPT_W'(REPEAT_RATE);
   localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   logic [NUM_BUTTONS-1:0] pressed_raw;
   logic [NUM_BUTTONS-1:0] sync1;
   logic [NUM_BUTTONS-1:0] sync2;

   logic [DB_W-1:0]  db_cnt       [NUM_BUTTONS];
   logic [DB_W-1:0]  db_cnt_next  [NUM_BUTTONS];
   logic [RPT_W-1:0] rpt_cnt      [NUM_BUTTONS];
   logic [RPT_W-1:0] rpt_cnt_next [NUM_BUTTONS];
   rpt_state_t       state        [NUM_BUTTONS];
   rpt_state_t       state_next   [NUM_BUTTONS];

   logic [NUM_BUTTONS-1:0] level_next;
   logic [NUM_BUTTONS-1:0] press_next;
   logic [NUM_BUTTONS-1:0] release_next;
   logic [NUM_BUTTONS-1:0] repeat_next;
   logic [NUM_BUTTONS-1:0] action_next;

   // Normalise to 1 = pressed before the synchroniser so its reset value means released.
   assign pressed_raw = ACTIVE_LOW ? ~raw_buttons : raw_buttons;

   always_comb begin
      level_next   = level;
      press_next   = '0;
      release_next = '0;
      repeat_next  = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         db_cnt_next[i]  = '0;
         rpt_cnt_next[i] = rpt_cnt[i];
         state_next[i]   = state[i];

         if (sync2[i] != level[i]) begin
            if (db_cnt[i] == DB_LAST) begin
               level_next[i] = sync2[i];
            end else begin
               db_cnt_next[i] = db_cnt[i] + DB_ONE;
            end
         end

         // Edges are taken from the level about to be registered so the pulse
         // appears in the same cycle as the new level.
         press_next[i]   = enable & level_next[i] & ~level[i];
         release_next[i] = enable & ~level_next[i] & level[i];

         // A falling level or a dropped enable wins over any pending repeat.
         if (!enable || !level_next[i]) begin
            state_next[i]   = IDLE;
            rpt_cnt_next[i] = '0;
         end else begin
            case (state[i])
               IDLE: begin
                  if (press_next[i] && REPEAT_MASK[i]) begin
                     state_next[i]   = DELAY;
                     rpt_cnt_next[i] = RPT_ONE;
                  end
               end
               DELAY: begin
                  if (rpt_cnt[i] == DELAY_END) begin
                     repeat_next[i]  = 1'b1;
                     state_next[i]   = REPEAT;
                     rpt_cnt_next[i] = RPT_ONE;
                  end else begin
                     rpt_cnt_next[i] = rpt_cnt[i] + RPT_ONE;
                  end
               end
               REPEAT: begin
                  if (rpt_cnt[i] == RATE_END) begin
                     repeat_next[i]  = 1'b1;
                     rpt_cnt_next[i] = RPT_ONE;
                  end else begin
                     rpt_cnt_next[i] = rpt_cnt[i] + RPT_ONE;
                  end
               end
               default: begin
                  state_next[i]   = IDLE;
                  rpt_cnt_next[i] = '0;
               end
            endcase
         end
      end
      action_next = press_next | repeat_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1         <= '0;
         sync2         <= '0;
         level         <= '0;
         press         <= '0;
         release_pulse <= '0;
         action        <= '0;
         any_action    <= 1'b0;
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            db_cnt[i]  <= '0;
            rpt_cnt[i] <= '0;
            state[i]   <= IDLE;
         end
      end else begin
         sync1         <= pressed_raw;
         sync2         <= sync1;
         level         <= level_next;
         press         <= press_next;
         release_pulse <= release_next;
         action        <= action_next;
         any_action    <= |action_next;
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            db_cnt[i]  <= db_cnt_next[i];
            rpt_cnt[i] <= rpt_cnt_next[i];
            state[i]   <= state_next[i];
         end
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed scoreboard bench for button_conditioner

module tb_button_conditioner;

   localparam int N = 4;

   localparam int SIG_LEVEL  = 0;
   localparam int SIG_PRESS  = 1;
   localparam int SIG_REL    = 2;
   localparam int SIG_ACTION = 3;
   localparam int SIG_ANY    = 4;

   logic         clk;
   logic         reset;
   logic [N-1:0] raw_buttons;
   logic         enable;
   logic [N-1:0] level;
   logic [N-1:0] press;
   logic [N-1:0] rel;
   logic [N-1:0] action;
   logic         any_action;

   int cyc;
   int n_checks;
   int n_fail;

   typedef struct {
      int    cyc;
      int    sig;
      int    idx;
      logic  val;
      string tag;
   } exp_t;

   exp_t exp_q[$];

   button_conditioner #(
      .NUM_BUTTONS     (N),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_RATE     (3),
      .REPEAT_MASK     (4'b0111),
      .ACTIVE_LOW      (1'b1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .raw_buttons   (raw_buttons),
      .enable        (enable),
      .level         (level),
      .press         (press),
      .release_pulse (rel),
      .action        (action),
      .any_action    (any_action)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout, required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic pick(int sig, int idx);
      case (sig)
         SIG_LEVEL:  return level[idx];
         SIG_PRESS:  return press[idx];
         SIG_REL:    return rel[idx];
         SIG_ACTION: return action[idx];
         default:    return any_action;
      endcase
   endfunction

   task automatic expect_at(int c, int sig, int idx, logic val, string tag);
      exp_t e;
      e.cyc = c;
      e.sig = sig;
      e.idx = idx;
      e.val = val;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic expect_rng(int c0, int c1, int sig, int idx, logic val, string tag);
      for (int c = c0; c <= c1; c++) expect_at(c, sig, idx, val, tag);
   endtask

   task automatic check_due();
      for (int k = exp_q.size() - 1; k >= 0; k--) begin
         if (exp_q[k].cyc == cyc) begin
            logic got;
            got = pick(exp_q[k].sig, exp_q[k].idx);
            n_checks++;
            assert (got === exp_q[k].val) else begin
               n_fail++;
               $error("FAIL %s cyc=%0d observed=%b expected=%b",
                      exp_q[k].tag, cyc, got, exp_q[k].val);
            end
            exp_q.delete(k);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_due();
   endtask

   task automatic step_to(int c);
      while (cyc < c) step();
   endtask

   task automatic check_now(string tag, logic [N:0] got, logic [N:0] want);
      n_checks++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, got, want);
      end
   endtask

   initial begin
      int c;
      int p;
      int q;
      int r;

      n_checks    = 0;
      n_fail      = 0;
      reset       = 1'b0;
      enable      = 1'b1;
      raw_buttons = 4'hF;

      #1;
      check_now("reset_level", {1'b0, level}, '0);
      check_now("reset_pulses", {any_action, press | rel | action}, '0);

      repeat (3) step();
      reset = 1'b1;
      repeat (2) step();

      // Button 0: debounce latency, press, auto-repeat cadence, release priority
      c = cyc;
      raw_buttons[0] = 1'b0;
      p = c + 6;
      expect_at(p - 1, SIG_LEVEL, 0, 1'b0, "t1_level_before");
      expect_at(p, SIG_LEVEL, 0, 1'b1, "t1_level_rise");
      expect_at(p, SIG_PRESS, 0, 1'b1, "t1_press");
      expect_at(p + 1, SIG_PRESS, 0, 1'b0, "t1_press_one_cycle");
      expect_at(p, SIG_ANY, 0, 1'b1, "t1_any");
      expect_rng(c + 1, p - 1, SIG_ACTION, 0, 1'b0, "t1_action_quiet");
      expect_at(p, SIG_ACTION, 0, 1'b1, "t1_action_press");
      expect_rng(p + 1, p + 9, SIG_ACTION, 0, 1'b0, "t1_action_delay");
      expect_at(p + 10, SIG_ACTION, 0, 1'b1, "t1_repeat0");
      expect_rng(p + 11, p + 12, SIG_ACTION, 0, 1'b0, "t1_gap0");
      expect_at(p + 13, SIG_ACTION, 0, 1'b1, "t1_repeat1");
      expect_rng(p + 14, p + 15, SIG_ACTION, 0, 1'b0, "t1_gap1");
      expect_at(p + 16, SIG_ACTION, 0, 1'b1, "t1_repeat2");
      expect_rng(p + 17, p + 22, SIG_ACTION, 0, 1'b0, "t1_no_repeat_at_release");
      expect_at(p + 18, SIG_LEVEL, 0, 1'b1, "t1_level_held");
      expect_at(p + 19, SIG_LEVEL, 0, 1'b0, "t1_level_fall");
      expect_at(p + 18, SIG_REL, 0, 1'b0, "t1_release_early");
      expect_at(p + 19, SIG_REL, 0, 1'b1, "t1_release");
      expect_at(p + 20, SIG_REL, 0, 1'b0, "t1_release_one_cycle");
      step_to(p + 13);
      raw_buttons[0] = 1'b1;
      step_to(p + 25);

      // Button 1: three-cycle glitch must be filtered
      c = cyc;
      raw_buttons[1] = 1'b0;
      expect_rng(c + 1, c + 12, SIG_LEVEL, 1, 1'b0, "t2_glitch_level");
      expect_rng(c + 1, c + 12, SIG_PRESS, 1, 1'b0, "t2_glitch_press");
      expect_rng(c + 1, c + 12, SIG_ACTION, 1, 1'b0, "t2_glitch_action");
      repeat (3) step();
      raw_buttons[1] = 1'b1;
      step_to(c + 14);

      // Button 3: repeat masked off, one action pulse over a long hold
      c = cyc;
      raw_buttons[3] = 1'b0;
      expect_rng(c + 1, c + 5, SIG_ACTION, 3, 1'b0, "t3_action_before");
      expect_at(c + 6, SIG_ACTION, 3, 1'b1, "t3_action_press");
      expect_rng(c + 7, c + 60, SIG_ACTION, 3, 1'b0, "t3_no_repeat");
      expect_at(c + 56, SIG_REL, 3, 1'b1, "t3_release");
      step_to(c + 50);
      raw_buttons[3] = 1'b1;
      step_to(c + 62);

      // Buttons 0 and 2 on the same edge
      c = cyc;
      raw_buttons[0] = 1'b0;
      raw_buttons[2] = 1'b0;
      expect_at(c + 6, SIG_PRESS, 0, 1'b1, "t4_press0");
      expect_at(c + 6, SIG_PRESS, 2, 1'b1, "t4_press2");
      expect_at(c + 6, SIG_PRESS, 1, 1'b0, "t4_press1_idle");
      expect_at(c + 6, SIG_PRESS, 3, 1'b0, "t4_press3_idle");
      expect_at(c + 5, SIG_ANY, 0, 1'b0, "t4_any_before");
      expect_at(c + 6, SIG_ANY, 0, 1'b1, "t4_any");
      expect_at(c + 7, SIG_ANY, 0, 1'b0, "t4_any_after");
      expect_at(c + 14, SIG_LEVEL, 2, 1'b0, "t4_level2_fall");
      expect_at(c + 14, SIG_REL, 2, 1'b1, "t4_release2");
      expect_at(c + 14, SIG_REL, 0, 1'b1, "t4_release0");
      step_to(c + 8);
      raw_buttons[0] = 1'b1;
      raw_buttons[2] = 1'b1;
      step_to(c + 20);

      // Enable dropped mid-repeat, raised again while held
      c = cyc;
      raw_buttons[0] = 1'b0;
      p = c + 6;
      expect_at(p, SIG_PRESS, 0, 1'b1, "t5_press");
      expect_at(p + 10, SIG_ACTION, 0, 1'b1, "t5_repeat_before_disable");
      expect_rng(p + 11, p + 45, SIG_ACTION, 0, 1'b0, "t5_action_gated");
      expect_rng(p + 11, p + 45, SIG_ANY, 0, 1'b0, "t5_any_gated");
      expect_rng(p + 11, p + 45, SIG_PRESS, 0, 1'b0, "t5_no_press_on_enable");
      expect_at(p + 15, SIG_LEVEL, 0, 1'b1, "t5_level_tracks");
      expect_at(p + 46, SIG_LEVEL, 0, 1'b0, "t5_level_fall");
      expect_at(p + 46, SIG_REL, 0, 1'b1, "t5_release");
      step_to(p + 10);
      enable = 1'b0;
      step_to(p + 19);
      enable = 1'b1;
      step_to(p + 40);
      raw_buttons[0] = 1'b1;
      step_to(p + 50);
      raw_buttons[0] = 1'b0;
      q = p + 56;
      expect_at(q, SIG_PRESS, 0, 1'b1, "t5_repress");
      expect_at(q + 10, SIG_ACTION, 0, 1'b1, "t5_repeat_after_repress");
      expect_at(q + 13, SIG_ACTION, 0, 1'b1, "t5_repeat_after_repress2");
      step_to(q + 14);

      // Reset mid-repeat: clears without a clock, no pulse, then held button re-qualifies
      reset = 1'b0;
      #1;
      check_now("t6_async_level", {1'b0, level}, '0);
      check_now("t6_async_pulses", {any_action, press | rel | action}, '0);
      expect_rng(q + 15, q + 17, SIG_LEVEL, 0, 1'b0, "t6_level_in_reset");
      expect_rng(q + 15, q + 17, SIG_ACTION, 0, 1'b0, "t6_action_in_reset");
      repeat (3) step();
      reset = 1'b1;
      r = cyc;
      expect_rng(r + 1, r + 5, SIG_LEVEL, 0, 1'b0, "t6_level_requalify");
      expect_rng(r + 1, r + 5, SIG_ACTION, 0, 1'b0, "t6_no_pulse_after_reset");
      expect_at(r + 6, SIG_LEVEL, 0, 1'b1, "t6_level_rise");
      expect_at(r + 6, SIG_PRESS, 0, 1'b1, "t6_press");
      expect_at(r + 16, SIG_ACTION, 0, 1'b1, "t6_repeat");
      step_to(r + 18);
      raw_buttons[0] = 1'b1;
      step_to(r + 30);

      n_checks++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drained observed=%0d expected=0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
